// File: rtl/seg7_axis_decoder.sv
// ---------------------------------------------------------------------------
// seg7_axis_decoder
//   Takes an AXI-Stream of 2-digit 7-segment frames and turns each frame back
//   into a byte made of two hex nibbles. Each byte is zero-extended to W bits
//   and sent out through a 2-entry output FIFO. A frame holding a pattern that
//   is not in the decode table is either passed through with m_err=1 or
//   dropped, depending on DROP_ERR. Either way it is counted in err_cnt.
//
// Ports
//   clk      in   clock, rising edge
//   rstn     in   asynchronous active-low reset. Release is synchronised inside.
//   s_valid  in   input frame valid
//   s_ready  out  input frame accepted on s_valid && s_ready
//   s_data   in   [1:0][6:0]; [0] = high digit, [1] = low digit, bits {g..a}
//   m_valid  out  output word valid
//   m_ready  in   downstream accepts on m_valid && m_ready
//   m_data   out  W bits: {0.., hi_nibble, lo_nibble}
//   m_err    out  1 = word came from a frame with an illegal digit
//   err_cnt  out  CW bits: saturating count of illegal frames
// ---------------------------------------------------------------------------
module seg7_axis_decoder #(
  parameter int W        = 16,
  parameter bit DROP_ERR = 1'b0,
  parameter int CW       = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [1:0][6:0]      s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [W-1:0]         m_data,
  output logic                 m_err,
  output logic [CW-1:0]        err_cnt
);

  // Result is {illegal, nibble}. Blank (all segments off) reads as a legal 0.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h3F:   r = 5'h00;
      7'h06:   r = 5'h01;
      7'h5B:   r = 5'h02;
      7'h4F:   r = 5'h03;
      7'h66:   r = 5'h04;
      7'h6D:   r = 5'h05;
      7'h7D:   r = 5'h06;
      7'h07:   r = 5'h07;
      7'h7F:   r = 5'h08;
      7'h6F:   r = 5'h09;
      7'h77:   r = 5'h0A;
      7'h7C:   r = 5'h0B;
      7'h39:   r = 5'h0C;
      7'h5E:   r = 5'h0D;
      7'h79:   r = 5'h0E;
      7'h71:   r = 5'h0F;
      7'h00:   r = 5'h00;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  // Reset synchroniser. Assertion is asynchronous. Release takes two edges.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rst_sync_q <= 2'b00;
    else       rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_int_n = rst_sync_q[1];

  // Decode of the incoming frame
  logic [4:0] dec_hi, dec_lo;
  logic       frame_bad;
  logic [8:0] new_ent;

  assign dec_hi    = seg_decode(s_data[0]);
  assign dec_lo    = seg_decode(s_data[1]);
  assign frame_bad = dec_hi[4] | dec_lo[4];
  assign new_ent   = {frame_bad, dec_hi[3:0], dec_lo[3:0]};

  // Output FIFO: entry 0 is the head, entry 1 the tail. An entry is {err, byte}.
  logic [8:0] ent0_q, ent0_d;
  logic [8:0] ent1_q, ent1_d;
  logic [1:0] count_q, count_d;
  logic [CW-1:0] err_cnt_q, err_cnt_d;

  logic accept, push, pop;

  assign s_ready = (count_q != 2'd2) || m_ready;
  assign accept  = s_valid && s_ready;
  assign push    = accept && !(DROP_ERR && frame_bad);
  assign pop     = m_ready && (count_q != 2'd0);

  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) ent0_d = new_ent;
        else                 ent1_d = new_ent;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        ent0_d  = ent1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Count is unchanged. Only the data moves forward.
        if (count_q == 2'd1) begin
          ent0_d = new_ent;
        end else begin
          ent0_d = ent1_q;
          ent1_d = new_ent;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && frame_bad && (err_cnt_q != {CW{1'b1}}))
      err_cnt_d = err_cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      ent0_q    <= '0;
      ent1_q    <= '0;
      count_q   <= 2'd0;
      err_cnt_q <= '0;
    end else begin
      ent0_q    <= ent0_d;
      ent1_q    <= ent1_d;
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign m_valid = (count_q != 2'd0);
  assign m_data  = W'(ent0_q[7:0]);
  assign m_err   = ent0_q[8];
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_seg7_axis_decoder.sv
module tb_seg7_axis_decoder;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic            clk = 1'b0;
  logic            rstn;
  logic            sv [3];
  logic            sr [3];
  logic [1:0][6:0] sd [3];
  logic            mv [3];
  logic            mr [3];
  logic [15:0]     md [3];
  logic            me [3];
  logic [15:0]     ec0, ec1;
  logic [1:0]      ec2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference state
  logic [8:0] exp_q [3][$];
  int         err_model [3];
  int         err_max   [3] = '{65535, 65535, 3};
  bit         drop_m    [3] = '{1'b0, 1'b1, 1'b0};

  bit rand_ready = 1'b0;
  bit log_en     = 1'b0;
  int acc_cyc[$];
  int out_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seg7_axis_decoder #(.W(16), .DROP_ERR(1'b0), .CW(16)) dut0 (
    .clk(clk), .rstn(rstn), .s_valid(sv[0]), .s_ready(sr[0]), .s_data(sd[0]),
    .m_valid(mv[0]), .m_ready(mr[0]), .m_data(md[0]), .m_err(me[0]), .err_cnt(ec0));

  seg7_axis_decoder #(.W(16), .DROP_ERR(1'b1), .CW(16)) dut1 (
    .clk(clk), .rstn(rstn), .s_valid(sv[1]), .s_ready(sr[1]), .s_data(sd[1]),
    .m_valid(mv[1]), .m_ready(mr[1]), .m_data(md[1]), .m_err(me[1]), .err_cnt(ec1));

  seg7_axis_decoder #(.W(16), .DROP_ERR(1'b0), .CW(2)) dut2 (
    .clk(clk), .rstn(rstn), .s_valid(sv[2]), .s_ready(sr[2]), .s_data(sd[2]),
    .m_valid(mv[2]), .m_ready(mr[2]), .m_data(md[2]), .m_err(me[2]), .err_cnt(ec2));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int get_ec(input int k);
    if (k == 0) return int'(ec0);
    if (k == 1) return int'(ec1);
    return int'(ec2);
  endfunction

  // Reference decode: look the pattern up in the table. Blank is a legal 0.
  // Anything else is illegal and reads as 0.
  function automatic void ref_digit(input logic [6:0] p, output logic [3:0] n, output bit bad);
    n   = 4'h0;
    bad = (p != 7'h00);
    for (int i = 0; i < 16; i++)
      if (p == SEG_TAB[i]) begin
        n   = 4'(i);
        bad = 1'b0;
      end
  endfunction

  function automatic void model_accept(input int k, input logic [6:0] hi, input logic [6:0] lo);
    logic [3:0] nh, nl;
    bit bh, bl;
    ref_digit(hi, nh, bh);
    ref_digit(lo, nl, bl);
    if ((bh || bl) && err_model[k] < err_max[k]) err_model[k]++;
    if (!((bh || bl) && drop_m[k])) exp_q[k].push_back({bh || bl, nh, nl});
  endfunction

  task automatic send(input int k, input logic [6:0] hi, input logic [6:0] lo);
    bit done = 1'b0;
    int tries = 0;
    @(negedge clk);
    sv[k] = 1'b1;
    sd[k][0] = hi;
    sd[k][1] = lo;
    while (!done && tries < 200) begin
      #1;
      if (sr[k]) begin
        @(posedge clk);
        model_accept(k, hi, lo);
        done = 1'b1;
      end else begin
        @(negedge clk);
        tries++;
      end
    end
    #1;
    sv[k] = 1'b0;
    if (log_en) acc_cyc.push_back(cyc);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout dut%0d: frame not accepted within 200 cycles", k);
    end
  endtask

  task automatic drain(input int k);
    int n = 0;
    while (exp_q[k].size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #2;
    chk($sformatf("drain_empty dut%0d", k), exp_q[k].size(), 0);
  endtask

  function automatic logic [6:0] rand_seg();
    int r = int'($urandom_range(0, 9));
    if (r < 8) return SEG_TAB[$urandom_range(0, 15)];
    if (r == 8) return 7'h00;
    return 7'($urandom_range(0, 127));
  endfunction

  // Random backpressure on dut0
  initial forever begin
    @(negedge clk);
    if (rand_ready) mr[0] = 1'($urandom_range(0, 1));
  end

  // One scoreboard monitor per DUT. A word is taken when m_valid && m_ready
  // is seen just before the edge. A stalled word must not change.
  for (genvar g = 0; g < 3; g++) begin : g_mon
    bit         hold_p = 1'b0;
    logic [16:0] hold_v;
    logic [8:0]  e;
    initial forever begin
      @(negedge clk);
      #1;
      if (rstn) begin
        if (hold_p && mv[g])
          chk($sformatf("hold dut%0d", g), int'({me[g], md[g]}), int'(hold_v));
        if (mv[g] && mr[g]) begin
          if (exp_q[g].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word dut%0d: got 0x%0h expected none", g, md[g]);
          end else begin
            e = exp_q[g].pop_front();
            chk($sformatf("m_data dut%0d", g), int'(md[g]), int'({8'h00, e[7:0]}));
            chk($sformatf("m_err dut%0d", g), int'(me[g]), int'(e[8]));
            if (g == 0 && log_en) out_cyc.push_back(cyc);
          end
        end
        hold_p = mv[g] && !mr[g];
        hold_v = {me[g], md[g]};
      end else begin
        hold_p = 1'b0;
      end
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      sv[k] = 1'b0;
      sd[k] = '0;
      mr[k] = 1'b1;
      err_model[k] = 0;
    end
    rstn = 1'b0;
    #23;
    // Reset state
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst m_valid dut%0d", k), int'(mv[k]), 0);
      chk($sformatf("rst m_data dut%0d", k), int'(md[k]), 0);
      chk($sformatf("rst m_err dut%0d", k), int'(me[k]), 0);
      chk($sformatf("rst err_cnt dut%0d", k), get_ec(k), 0);
      chk($sformatf("rst s_ready dut%0d", k), int'(sr[k]), 1);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("s_ready after release", int'(sr[0]), 1);
    repeat (4) @(negedge clk);

    // Streaming with one-cycle latency
    log_en = 1'b1;
    send(0, 7'h4F, 7'h06);
    send(0, 7'h3F, 7'h7F);
    send(0, 7'h5B, 7'h66);
    drain(0);
    log_en = 1'b0;
    chk("latency count", out_cyc.size(), 3);
    for (int i = 0; i < 3 && i < out_cyc.size() && i < acc_cyc.size(); i++)
      chk($sformatf("latency word%0d", i), out_cyc[i] - acc_cyc[i], 0);

    // Backpressure
    mr[0] = 1'b0;
    send(0, 7'h6D, 7'h6D);
    send(0, 7'h07, 7'h07);
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("bp s_ready", int'(sr[0]), 0);
      chk("bp m_valid", int'(mv[0]), 1);
      chk("bp m_data", int'(md[0]), 16'h0055);
    end
    @(negedge clk);
    mr[0] = 1'b1;
    send(0, 7'h7F, 7'h7F);
    drain(0);

    // Illegal digits passed through with m_err
    send(0, 7'h12, 7'h06);
    @(negedge clk);
    #1;
    chk("err frame m_data", int'(md[0]), 16'h0001);
    chk("err frame m_err", int'(me[0]), 1);
    chk("err_cnt one", int'(ec0), 1);
    send(0, 7'h12, 7'h13);
    drain(0);
    chk("err_cnt once per frame", int'(ec0), 2);

    // Drop mode
    send(1, 7'h06, 7'h06);
    send(1, 7'h12, 7'h3F);
    send(1, 7'h07, 7'h07);
    drain(1);
    chk("drop err_cnt", int'(ec1), 1);

    // Saturation with CW=2
    repeat (5) send(2, 7'h12, 7'h12);
    drain(2);
    chk("sat err_cnt", int'(ec2), 3);
    chk("sat model", get_ec(2), err_model[2]);

    // Reset with two words queued
    mr[0] = 1'b0;
    send(0, 7'h06, 7'h5B);
    send(0, 7'h4F, 7'h66);
    @(negedge clk);
    #2;
    chk("pre-reset m_valid", int'(mv[0]), 1);
    rstn = 1'b0;
    #1;
    chk("midrst m_valid", int'(mv[0]), 0);
    chk("midrst m_data", int'(md[0]), 0);
    chk("midrst err_cnt", int'(ec0), 0);
    for (int k = 0; k < 3; k++) begin
      exp_q[k].delete();
      err_model[k] = 0;
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    mr[0] = 1'b1;
    send(0, 7'h77, 7'h71);
    @(negedge clk);
    #1;
    chk("post-reset first word", int'(md[0]), 16'h00AF);
    drain(0);

    // Random traffic and backpressure against the reference model
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(0, rand_seg(), rand_seg());
    end
    @(negedge clk);
    rand_ready = 1'b0;
    mr[0] = 1'b1;
    drain(0);
    chk("random err_cnt", int'(ec0), err_model[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
